// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: size/alignment check, byte-lane steering,
// req/ack memory handshake and sign/zero extension of returned load data.
module load_store_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ex_valid,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic                  lsu_busy,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic                  access_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state_reg, state_next;

    logic                  request;
    logic                  is_load;
    logic                  size_ok;
    logic                  align_ok;
    logic                  accept;
    logic                  reject;
    logic                  handshake;
    logic [3:0]            be_next;
    logic [DATA_WIDTH-1:0] byte_rep;
    logic [DATA_WIDTH-1:0] half_rep;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_ext;

    logic                  access_err_reg;
    logic                  mem_we_reg;
    logic [DATA_WIDTH-1:0] mem_addr_reg;
    logic [DATA_WIDTH-1:0] mem_wdata_reg;
    logic [3:0]            mem_be_reg;
    logic [DATA_WIDTH-1:0] rd_data_reg;
    logic [1:0]            off_reg;
    logic [1:0]            size_reg;
    logic                  unsigned_reg;

    // MemRead wins when both strobes are high.
    assign request = ex_valid && (MemRead || MemWrite);
    assign is_load = MemRead;

    always_comb begin
        size_ok = 1'b0;
        case (Funct3)
            3'b000, 3'b001, 3'b010: size_ok = 1'b1;
            3'b100, 3'b101:         size_ok = is_load;
            default:                size_ok = 1'b0;
        endcase
    end

    always_comb begin
        align_ok = 1'b1;
        case (Funct3[1:0])
            2'b01:   align_ok = ~ALUResult[0];
            2'b10:   align_ok = (ALUResult[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    assign accept    = (state_reg == IDLE) && request && size_ok && align_ok;
    assign reject    = (state_reg == IDLE) && request && !(size_ok && align_ok);
    assign handshake = (state_reg == REQ) && mem_ack;

    always_comb begin
        be_next = 4'b1111;
        case (Funct3[1:0])
            2'b00:   be_next = 4'b0001 << ALUResult[1:0];
            2'b01:   be_next = ALUResult[1] ? 4'b1100 : 4'b0011;
            default: be_next = 4'b1111;
        endcase
    end

    // Narrow store data is replicated to every lane; mem_be selects the live one.
    for (genvar gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_byte_rep
        assign byte_rep[8*gi +: 8] = WrData[7:0];
    end
    for (genvar gi = 0; gi < DATA_WIDTH / 16; gi++) begin : g_half_rep
        assign half_rep[16*gi +: 16] = WrData[15:0];
    end

    always_comb begin
        wdata_next = '0;
        if (!is_load) begin
            case (Funct3[1:0])
                2'b00:   wdata_next = byte_rep;
                2'b01:   wdata_next = half_rep;
                default: wdata_next = WrData;
            endcase
        end
    end

    assign byte_sel = mem_rdata[8*off_reg +: 8];
    assign half_sel = mem_rdata[16*off_reg[1] +: 16];

    always_comb begin
        load_ext = mem_rdata;
        case (size_reg)
            2'b00:   load_ext = {{(DATA_WIDTH-8){~unsigned_reg & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{(DATA_WIDTH-16){~unsigned_reg & half_sel[15]}}, half_sel};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = REQ;
            REQ:     if (mem_ack) state_next = mem_we_reg ? IDLE : RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            access_err_reg <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_be_reg     <= 4'b0000;
            rd_data_reg    <= '0;
            off_reg        <= 2'b00;
            size_reg       <= 2'b00;
            unsigned_reg   <= 1'b0;
        end else begin
            access_err_reg <= reject;
            if (accept) begin
                mem_we_reg    <= !is_load;
                mem_addr_reg  <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                mem_wdata_reg <= wdata_next;
                mem_be_reg    <= be_next;
                off_reg       <= ALUResult[1:0];
                size_reg      <= Funct3[1:0];
                unsigned_reg  <= Funct3[2];
            end
            if (handshake && !mem_we_reg) begin
                rd_data_reg <= load_ext;
            end
        end
    end

    // Handshake outputs decode straight from the state so reset clears them at once.
    assign lsu_busy   = (state_reg != IDLE);
    assign mem_req    = (state_reg == REQ);
    assign rd_valid   = (state_reg == RESP);
    assign access_err = access_err_reg;
    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_be     = mem_be_reg;
    assign RdData     = rd_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized self-checking bench for load_store_unit against an arithmetic
// reference model of lane selection, replication and extension.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] ALUResult, WrData;
    logic        lsu_busy, rd_valid, access_err, mem_req, mem_we;
    logic [31:0] RdData, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        mem_ack;

    int total_count = 0;
    int pass_count  = 0;
    logic [31:0] last_rd = '0;

    load_store_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .Funct3(Funct3), .ALUResult(ALUResult), .WrData(WrData),
        .lsu_busy(lsu_busy), .rd_valid(rd_valid), .RdData(RdData),
        .access_err(access_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_count++;
        if (got === exp) pass_count++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Expected behaviour from the access size in bytes and the byte offset.
    function automatic void model(input bit rd, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  input logic [31:0] rdv, output bit legal,
                                  output logic [3:0] be, output logic [31:0] maddr,
                                  output logic [31:0] mwdata, output logic [31:0] rdexp);
        longint a, off, v, n;
        a   = longint'(addr);
        off = a % 4;
        case (f3[1:0])
            2'd0: n = 1;
            2'd1: n = 2;
            2'd2: n = 4;
            default: n = 0;
        endcase
        legal = (n != 0);
        if (legal) legal = (a % n == 0) && !(f3[2] && (!rd || n == 4));
        if (n == 0) n = 4;
        be    = 4'(((longint'(1) << n) - 1) << off);
        maddr = 32'(a - off);
        if (rd)          mwdata = '0;
        else if (n == 1) mwdata = 32'((longint'(wd) % 256) * 64'h01010101);
        else if (n == 2) mwdata = 32'((longint'(wd) % 65536) * 64'h00010001);
        else             mwdata = wd;
        v = (longint'(rdv) >> (8 * off)) % (longint'(1) << (8 * n));
        if (n < 4 && !f3[2] && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        rdexp = 32'(v);
    endfunction

    task automatic clear_issue();
        ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdv, input int delay, input bit noise);
        bit legal;
        logic [3:0]  be;
        logic [31:0] maddr, mwdata, rdexp, tmp;
        model(rd, f3, addr, wd, rdv, legal, be, maddr, mwdata, rdexp);
        @(negedge clk);
        ex_valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3;
        ALUResult = addr; WrData = wd; mem_ack = 1'b0;
        @(negedge clk);
        clear_issue();
        $display("op rd=%0b wr=%0b f3=%03b addr=%08h wd=%08h rdata=%08h delay=%0d legal=%0b",
                 rd, wr, f3, addr, wd, rdv, delay, legal);
        if (!legal) begin
            check("err_pulse", 32'(access_err), 32'd1);
            check("err_req", 32'(mem_req), 32'd0);
            check("err_busy", 32'(lsu_busy), 32'd0);
            @(negedge clk);
            check("err_one_cycle", 32'(access_err), 32'd0);
            check("err_req_later", 32'(mem_req), 32'd0);
            check("err_rddata_hold", RdData, last_rd);
            return;
        end
        check("no_err", 32'(access_err), 32'd0);
        for (int i = 0; i <= delay; i++) begin
            check("req", 32'(mem_req), 32'd1);
            check("busy", 32'(lsu_busy), 32'd1);
            check("we", 32'(mem_we), 32'(!rd));
            check("addr", mem_addr, maddr);
            check("be", 32'(mem_be), 32'(be));
            check("wdata", mem_wdata, mwdata);
            check("rdv_wait", 32'(rd_valid), 32'd0);
            if (i == delay) begin
                mem_ack = 1'b1; mem_rdata = rdv;
            end else if (noise) begin
                ex_valid = 1'b1; tmp = $urandom;
                MemRead = tmp[0]; MemWrite = ~tmp[0]; Funct3 = tmp[6:4];
                ALUResult = $urandom; WrData = $urandom; mem_rdata = $urandom;
            end
            @(negedge clk);
            clear_issue();
        end
        mem_ack = 1'b0; mem_rdata = $urandom;
        check("req_drop", 32'(mem_req), 32'd0);
        if (rd) begin
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_data", RdData, rdexp);
            check("resp_busy", 32'(lsu_busy), 32'd1);
            last_rd = rdexp;
            @(negedge clk);
            check("rd_valid_pulse", 32'(rd_valid), 32'd0);
            check("idle_busy", 32'(lsu_busy), 32'd0);
            check("rd_hold", RdData, last_rd);
        end else begin
            check("st_no_rdv", 32'(rd_valid), 32'd0);
            check("st_idle", 32'(lsu_busy), 32'd0);
            check("st_rd_hold", RdData, last_rd);
        end
    endtask

    task automatic idle_ack_noise();
        @(negedge clk);
        clear_issue();
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        $display("idle ack noise");
        check("idle_ack_rdv", 32'(rd_valid), 32'd0);
        check("idle_ack_busy", 32'(lsu_busy), 32'd0);
        check("idle_ack_rd", RdData, last_rd);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, 32'(lsu_busy), 32'd0);
        check({tag, "_rdv"}, 32'(rd_valid), 32'd0);
        check({tag, "_err"}, 32'(access_err), 32'd0);
        check({tag, "_req"}, 32'(mem_req), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_addr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_wdata, 32'd0);
        check({tag, "_rddata"}, RdData, 32'd0);
        check({tag, "_be"}, 32'(mem_be), 32'd0);
    endtask

    initial begin
        logic [31:0] r_addr, r_wd, r_rdv;
        int sel;
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
        Funct3 = 3'b000; ALUResult = '0; WrData = '0;
        clear_issue();
        @(negedge clk);
        @(negedge clk);
        $display("reset check");
        check_reset_values("rst");
        reset = 1'b0;

        run_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0, 0);
        run_op(1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 0, 0);
        run_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_1234, 1, 0);
        run_op(0, 1, 3'b000, 32'h201, 32'h1234_56AB, 32'h0, 0, 0);
        run_op(0, 1, 3'b001, 32'h202, 32'h1234_56AB, 32'h0, 0, 0);
        run_op(1, 0, 3'b010, 32'h302, 32'h0, 32'h0, 0, 0);
        run_op(0, 1, 3'b010, 32'h400, 32'hDEAD_BEEF, 32'h0, 5, 1);
        run_op(1, 1, 3'b100, 32'h111, 32'hFFFF_FFFF, 32'h00A5_0000, 2, 1);
        run_op(0, 1, 3'b100, 32'h120, 32'h55, 32'h0, 0, 0);
        idle_ack_noise();

        // Reset while a load waits for its ack.
        @(negedge clk);
        ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010;
        ALUResult = 32'h500; mem_ack = 1'b0; mem_rdata = 32'h1234_5678;
        @(negedge clk);
        clear_issue();
        $display("reset during REQ");
        check("pre_rst_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1 check_reset_values("mid_rst");
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1;
        last_rd = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rdv", 32'(rd_valid), 32'd0);
            check("post_rst_req", 32'(mem_req), 32'd0);
        end
        mem_ack = 1'b0;

        for (int k = 0; k < 150; k++) begin
            sel = $urandom_range(0, 2);
            r_addr = $urandom; r_wd = $urandom; r_rdv = $urandom;
            run_op(sel != 1, sel != 0, 3'($urandom_range(0, 7)), r_addr, r_wd, r_rdv,
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) idle_ack_noise();
        end

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: DATA_WIDTH, 32, datapath and address width.
REQ-002 Ports: clk  in  1  clock, all state updates on rising edge.
REQ-003 Ports: reset  in  1  asynchronous, active-high reset.
REQ-004 Ports: ex_valid  in  1  memory op issued from EX this cycle.
REQ-005 Ports: MemRead  in  1  load request; MemWrite  in  1  store request.
REQ-006 Ports: Funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
REQ-007 Ports: ALUResult  in  DATA_WIDTH  effective byte address from ALU.
REQ-008 Ports: WrData  in  DATA_WIDTH  store data (rs2).
REQ-009 Ports: lsu_busy  out  1  pipeline stall request.
REQ-010 Ports: rd_valid  out  1  one-cycle pulse, RdData valid; RdData  out  DATA_WIDTH  extended load data.
REQ-011 Ports: access_err  out  1  one-cycle pulse, op rejected.
REQ-012 Ports: mem_req, mem_we  out  1; mem_addr, mem_wdata  out  DATA_WIDTH; mem_be  out  4; mem_ack  in  1; mem_rdata  in  DATA_WIDTH.

Function
REQ-013 FSM states SHALL be IDLE, REQ, RESP; lsu_busy = (state != IDLE).
REQ-014 Accept: IDLE and ex_valid and (MemRead or MemWrite) SHALL be sampled at edge N; MemRead has priority when both high (treated as load).
REQ-015 Reject: H/HU with addr[0]=1, W with addr[1:0]!=0, or Funct3 outside REQ-006 (store with 1xx) SHALL pulse access_err in cycle N+1, state stays IDLE, no mem_req.
REQ-016 Legal accept SHALL register address, size, sign, data, direction and enter REQ; mem_req high from cycle N+1.
REQ-017 mem_addr SHALL be {addr[31:2],2'b00}; mem_we=1 for stores; all mem_* outputs stable while mem_req high.
REQ-018 Store lanes: B: be=0001<<addr[1:0], wdata={4{WrData[7:0]}}; H: be=0011 (addr[1]=0) or 1100, wdata={2{WrData[15:0]}}; W: be=1111, wdata=WrData.
REQ-019 Loads SHALL drive mem_be per REQ-018 lane rule; mem_wdata don't-care but driven 0.
REQ-020 Handshake completes at edge M where mem_req and mem_ack both high; mem_req SHALL drop in cycle M+1.
REQ-021 Store completion SHALL return to IDLE at M+1; no rd_valid.
REQ-022 Load completion SHALL capture mem_rdata, enter RESP at M+1 with rd_valid=1 and RdData valid for that cycle, then IDLE at M+2.
REQ-023 Load extraction: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; sign-extend for B/H, zero-extend for BU/HU.
REQ-024 RdData SHALL hold its last value until the next load completion.
REQ-025 mem_ack outside REQ SHALL be ignored; ex_valid while busy SHALL be ignored (upstream stalls on lsu_busy).
REQ-026 Minimum load latency (accept to rd_valid): 2 cycles with ack in first REQ cycle; store: 1 cycle busy.

Reset
REQ-027 reset SHALL force IDLE immediately, independent of clk.
REQ-028 Reset values: lsu_busy, rd_valid, access_err, mem_req, mem_we = 0; mem_addr, mem_wdata, RdData = 0; mem_be = 0000.
REQ-029 Reset mid-REQ SHALL drop mem_req asynchronously and discard the pending op; no rd_valid after release.

Verification
REQ-030 LB addr 0x103, mem_rdata 0x80FF_0000, ack immediate -> mem_addr 0x100, be 1000, rd_valid pulse with RdData 0xFFFF_FF80.
REQ-031 LHU addr 0x102, mem_rdata 0x8001_1234 -> RdData 0x0000_8001; LH same -> 0xFFFF_8001.
REQ-032 SB addr 0x201, WrData 0x1234_56AB -> mem_we=1, be 0010, wdata 0xABAB_ABAB; SH addr 0x202 -> be 1100, wdata 0x56AB_56AB.
REQ-033 LW addr 0x302 -> access_err one cycle, mem_req never asserted, lsu_busy stays 0.
REQ-034 SW addr 0x400, ack held low 5 cycles -> mem_req and lsu_busy high 6 cycles, outputs stable, busy drops cycle after ack; ex_valid pulses during wait ignored.
REQ-035 LW accepted, reset asserted in REQ with ack pending -> mem_req low immediately, all outputs at REQ-028 values, no rd_valid after release.
